// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: periodic read-only SPI master for a serial ADC (CPOL=1, sampled on SCLK rise).
// Each frame is CS_n low, one setup half-period, FRAME_BITS SCLK cycles, then a quiet gap.

// Protocol invariants on the registered outputs.
module adc_spi_sampler_checker (
   input  logic clk,
   input  logic rst,
   input  logic cs_n,
   input  logic sclk,
   input  logic sample_valid,
   input  logic busy
);
   a_sv_single_cycle : assert property (@(posedge clk) disable iff (rst) sample_valid |=> !sample_valid);
   a_sv_at_cs_rise   : assert property (@(posedge clk) disable iff (rst) sample_valid |-> (cs_n && busy));
   a_idle_lines      : assert property (@(posedge clk) disable iff (rst) !busy |-> (cs_n && sclk));
   a_cs_implies_busy : assert property (@(posedge clk) disable iff (rst) !cs_n |-> busy);
endmodule

module adc_spi_sampler #(
   parameter int HALF_DIV      = 25,
   parameter int FRAME_BITS    = 16,
   parameter int DATA_BITS     = 12,
   parameter int QUIET_CYCLES  = 50,
   parameter int SAMPLE_PERIOD = 1000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 miso,
   output logic                 cs_n,
   output logic                 sclk,
   output logic [DATA_BITS-1:0] voltage,
   output logic                 sample_valid,
   output logic                 busy,
   output logic                 overrun
);
   localparam int PH_W  = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam int BIT_W = $clog2(FRAME_BITS + 1);
   localparam int QT_W  = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
   localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

   localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(HALF_DIV - 1);
   localparam logic [QT_W-1:0]  QT_LAST    = QT_W'(QUIET_CYCLES - 1);
   localparam logic [PER_W-1:0] PER_LAST   = PER_W'(SAMPLE_PERIOD - 1);
   localparam logic [BIT_W-1:0] BIT_FRAME  = BIT_W'(FRAME_BITS);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_LOW   = 3'd2,
      ST_HIGH  = 3'd3,
      ST_QUIET = 3'd4
   } state_t;

   state_t               state_r;
   logic [PH_W-1:0]      phase_r;
   logic [QT_W-1:0]      quiet_r;
   logic [BIT_W-1:0]     bit_cnt_r;
   logic [PER_W-1:0]     period_r;
   logic [DATA_BITS-1:0] shift_r;
   logic                 tick_s;
   logic                 phase_done_s;

   assign tick_s       = (period_r == {PER_W{1'b0}});
   assign phase_done_s = (phase_r == PH_LAST);

   // Free-running frame-rate counter, independent of en and of the frame state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_r <= {PER_W{1'b0}};
      end else if (period_r == PER_LAST) begin
         period_r <= {PER_W{1'b0}};
      end else begin
         period_r <= period_r + PER_W'(1);
      end
   end

   // Frame sequencer; every output is driven from here so all outputs are registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         phase_r      <= {PH_W{1'b0}};
         quiet_r      <= {QT_W{1'b0}};
         bit_cnt_r    <= {BIT_W{1'b0}};
         shift_r      <= {DATA_BITS{1'b0}};
         cs_n         <= 1'b1;
         sclk         <= 1'b1;
         voltage      <= {DATA_BITS{1'b0}};
         sample_valid <= 1'b0;
         busy         <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         // A tick that finds a frame still in flight is dropped, not queued.
         overrun      <= tick_s && en && (state_r != ST_IDLE);
         case (state_r)
            ST_IDLE: begin
               cs_n      <= 1'b1;
               sclk      <= 1'b1;
               phase_r   <= {PH_W{1'b0}};
               quiet_r   <= {QT_W{1'b0}};
               bit_cnt_r <= {BIT_W{1'b0}};
               if (tick_s && en) begin
                  state_r <= ST_SETUP;
                  cs_n    <= 1'b0;
                  busy    <= 1'b1;
               end else begin
                  busy    <= 1'b0;
               end
            end
            ST_SETUP: begin
               if (phase_done_s) begin
                  phase_r <= {PH_W{1'b0}};
                  sclk    <= 1'b0;
                  state_r <= ST_LOW;
               end else begin
                  phase_r <= phase_r + PH_W'(1);
               end
            end
            ST_LOW: begin
               if (phase_done_s) begin
                  phase_r   <= {PH_W{1'b0}};
                  shift_r   <= {shift_r[DATA_BITS-2:0], miso};
                  bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                  sclk      <= 1'b1;
                  state_r   <= ST_HIGH;
               end else begin
                  phase_r   <= phase_r + PH_W'(1);
               end
            end
            ST_HIGH: begin
               if (phase_done_s) begin
                  phase_r <= {PH_W{1'b0}};
                  if (bit_cnt_r < BIT_FRAME) begin
                     sclk    <= 1'b0;
                     state_r <= ST_LOW;
                  end else begin
                     // Leading bits have already fallen off the top of shift_r.
                     cs_n         <= 1'b1;
                     voltage      <= shift_r;
                     sample_valid <= 1'b1;
                     state_r      <= ST_QUIET;
                  end
               end else begin
                  phase_r <= phase_r + PH_W'(1);
               end
            end
            ST_QUIET: begin
               if (quiet_r == QT_LAST) begin
                  quiet_r <= {QT_W{1'b0}};
                  busy    <= 1'b0;
                  state_r <= ST_IDLE;
               end else begin
                  quiet_r <= quiet_r + QT_W'(1);
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cs_n    <= 1'b1;
               sclk    <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   adc_spi_sampler_checker u_checker (
      .clk          (clk),
      .rst          (rst),
      .cs_n         (cs_n),
      .sclk         (sclk),
      .sample_valid (sample_valid),
      .busy         (busy)
   );

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Directed bench for adc_spi_sampler: default instance plus a SAMPLE_PERIOD=500 instance for overrun.
module tb_adc_spi_sampler;
   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic        rst = 1'b1, en = 1'b0, miso = 1'b0;
   logic        cs_n, sclk, sample_valid, busy, overrun;
   logic [11:0] voltage;
   logic        rst2 = 1'b1, en2 = 1'b1, miso2 = 1'b0;
   logic        cs_n2, sclk2, sample_valid2, busy2, overrun2;
   logic [11:0] voltage2;

   adc_spi_sampler dut (
      .clk(clk), .rst(rst), .en(en), .miso(miso), .cs_n(cs_n), .sclk(sclk),
      .voltage(voltage), .sample_valid(sample_valid), .busy(busy), .overrun(overrun));

   adc_spi_sampler #(.SAMPLE_PERIOD(500)) dut2 (
      .clk(clk), .rst(rst2), .en(en2), .miso(miso2), .cs_n(cs_n2), .sclk(sclk2),
      .voltage(voltage2), .sample_valid(sample_valid2), .busy(busy2), .overrun(overrun2));

   int tests_run = 0, tests_failed = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ADC models: next frame bit on every SCLK fall, bit index restarts when CS_n falls.
   logic [11:0] adc_word = 12'h000, adc_word2 = 12'h000;
   logic [15:0] frame_word, frame_word2;
   int          bit_idx = 0, bit_idx2 = 0;
   assign frame_word  = {4'b0000, adc_word};
   assign frame_word2 = {4'b0000, adc_word2};

   always @(negedge sclk or negedge cs_n) begin
      if (sclk === 1'b1) bit_idx <= 0;
      else if (cs_n === 1'b0 && bit_idx < 16) begin
         miso    <= frame_word[15 - bit_idx];
         bit_idx <= bit_idx + 1;
      end
   end

   always @(negedge sclk2 or negedge cs_n2) begin
      if (sclk2 === 1'b1) bit_idx2 <= 0;
      else if (cs_n2 === 1'b0 && bit_idx2 < 16) begin
         miso2    <= frame_word2[15 - bit_idx2];
         bit_idx2 <= bit_idx2 + 1;
      end
   end

   // Event monitors, sampled on the falling clock edge.
   logic cs_prev = 1'b1, sclk_prev = 1'b1, sv_prev = 1'b0, busy_prev = 1'b0;
   int   frame_rises = 0, cs_falls = 0, cs_fall_cyc = 0, cs_rise_cyc = 0, busy_fall_cyc = 0;
   int   edge_cyc = 0, phase_bad = 0, sv_count = 0, sv_cyc = 0, sv_long = 0, ov_count = 0;
   always @(negedge clk) begin
      if (cs_prev && !cs_n) begin
         cs_falls <= cs_falls + 1; cs_fall_cyc <= cyc; frame_rises <= 0; edge_cyc <= cyc;
      end
      if (!cs_n && cs_prev === 1'b0 && sclk !== sclk_prev) begin
         if (cyc - edge_cyc != 25) phase_bad <= phase_bad + 1;
         edge_cyc <= cyc;
         if (sclk) frame_rises <= frame_rises + 1;
      end
      if (!cs_prev && cs_n) begin
         cs_rise_cyc <= cyc;
         if (cyc - edge_cyc != 25) phase_bad <= phase_bad + 1;
      end
      if (busy_prev && !busy) busy_fall_cyc <= cyc;
      if (sample_valid) begin
         if (sv_prev) sv_long <= sv_long + 1;
         sv_count <= sv_count + 1; sv_cyc <= cyc;
      end
      if (overrun) ov_count <= ov_count + 1;
      cs_prev <= cs_n; sclk_prev <= sclk; sv_prev <= sample_valid; busy_prev <= busy;
   end

   logic cs2_prev = 1'b1, sv2_prev = 1'b0, ov2_prev = 1'b0;
   int   cs2_falls = 0, cs2_fall_cyc = 0, sv2_count = 0, sv2_cyc = 0, sv2_prev_cyc = 0;
   int   ov2_count = 0, ov2_cyc = 0, ov2_long = 0;
   always @(negedge clk) begin
      if (cs2_prev && !cs_n2) begin cs2_falls <= cs2_falls + 1; cs2_fall_cyc <= cyc; end
      if (sample_valid2) begin sv2_count <= sv2_count + 1; sv2_prev_cyc <= sv2_cyc; sv2_cyc <= cyc; end
      if (overrun2) begin
         if (ov2_prev) ov2_long <= ov2_long + 1;
         ov2_count <= ov2_count + 1; ov2_cyc <= cyc;
      end
      cs2_prev <= cs_n2; sv2_prev <= sample_valid2; ov2_prev <= overrun2;
   end

   int          n, r0, r1, q, nf, pb, last_sv;
   bit          ok;
   logic [11:0] ext_vals [3];

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_sv(input int base, output bit done);
      done = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         step();
         if (sv_count != base) begin done = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0;
      repeat (5) step();
      tests_run++; if (cs_n !== 1'b1) begin tests_failed++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
      tests_run++; if (sclk !== 1'b1) begin tests_failed++; $display("FAIL reset_sclk: got %b expected 1", sclk); end
      tests_run++; if (voltage !== 12'h000) begin tests_failed++; $display("FAIL reset_voltage: got %h expected 000", voltage); end
      tests_run++; if (sample_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_sv: got %b expected 0", sample_valid); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
      tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
   endtask

   task automatic test_single_frame();
      adc_word = 12'hABC; en = 1'b1;
      step();
      rst = 1'b0; r0 = cyc; n = sv_count; pb = phase_bad;
      wait_sv(n, ok);
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL single_timeout: no sample_valid within 2000 cycles"); end
      repeat (60) step();
      tests_run++; if (cs_fall_cyc !== r0 + 1) begin tests_failed++; $display("FAIL single_first_tick: cs_n fell at %0d expected %0d", cs_fall_cyc, r0 + 1); end
      tests_run++; if (frame_rises !== 16) begin tests_failed++; $display("FAIL single_sclk_rises: got %0d expected 16", frame_rises); end
      tests_run++; if (phase_bad !== pb) begin tests_failed++; $display("FAIL single_half_period: %0d phases not 25 cycles, expected 0", phase_bad - pb); end
      tests_run++; if (cs_rise_cyc - cs_fall_cyc !== 825) begin tests_failed++; $display("FAIL single_cs_low: got %0d expected 825", cs_rise_cyc - cs_fall_cyc); end
      tests_run++; if (voltage !== 12'hABC) begin tests_failed++; $display("FAIL single_voltage: got %h expected abc", voltage); end
      tests_run++; if (sv_cyc !== cs_rise_cyc) begin tests_failed++; $display("FAIL single_sv_timing: sv at %0d expected %0d", sv_cyc, cs_rise_cyc); end
      tests_run++; if (sv_count !== n + 1) begin tests_failed++; $display("FAIL single_sv_count: got %0d expected %0d", sv_count, n + 1); end
      tests_run++; if (busy_fall_cyc - cs_rise_cyc !== 50) begin tests_failed++; $display("FAIL single_quiet: got %0d expected 50", busy_fall_cyc - cs_rise_cyc); end
   endtask

   task automatic test_data_extremes();
      ext_vals[0] = 12'hFFF; ext_vals[1] = 12'h000; ext_vals[2] = 12'h800;
      last_sv = sv_cyc;
      for (int i = 0; i < 3; i++) begin
         adc_word = ext_vals[i]; n = sv_count;
         wait_sv(n, ok);
         tests_run++; if (!ok) begin tests_failed++; $display("FAIL extreme_timeout_%0d: no sample_valid", i); end
         tests_run++; if (voltage !== ext_vals[i]) begin tests_failed++; $display("FAIL extreme_voltage_%0d: got %h expected %h", i, voltage, ext_vals[i]); end
         tests_run++; if (sv_cyc - last_sv !== 1000) begin tests_failed++; $display("FAIL extreme_interval_%0d: got %0d expected 1000", i, sv_cyc - last_sv); end
         last_sv = sv_cyc;
      end
      tests_run++; if (ov_count !== 0) begin tests_failed++; $display("FAIL extreme_overrun: got %0d pulses expected 0", ov_count); end
   endtask

   task automatic test_enable_gating();
      adc_word = 12'h5A5; n = sv_count; ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         step();
         if (!cs_n && frame_rises == 8) begin ok = 1'b1; break; end
      end
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL gate_edge8_wait: SCLK edge 8 not seen"); end
      en = 1'b0; nf = cs_falls;
      wait_sv(n, ok);
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL gate_timeout: frame did not complete after en drop"); end
      tests_run++; if (voltage !== 12'h5A5) begin tests_failed++; $display("FAIL gate_voltage: got %h expected 5a5", voltage); end
      while (cyc < r0 + 7300) step();
      tests_run++; if (cs_falls !== nf) begin tests_failed++; $display("FAIL gate_no_start: %0d frames started, expected 0", cs_falls - nf); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL gate_busy: got %b expected 0", busy); end
      adc_word = 12'h123; en = 1'b1; n = sv_count;
      wait_sv(n, ok);
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL gate_resume_timeout: no frame after en raised"); end
      tests_run++; if (cs_fall_cyc !== r0 + 8001) begin tests_failed++; $display("FAIL gate_resume_tick: cs_n fell at %0d expected %0d", cs_fall_cyc, r0 + 8001); end
      tests_run++; if (voltage !== 12'h123) begin tests_failed++; $display("FAIL gate_resume_voltage: got %h expected 123", voltage); end
   endtask

   task automatic test_reset_mid_frame();
      adc_word = 12'h321; ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         step();
         if (!cs_n && frame_rises == 10) begin ok = 1'b1; break; end
      end
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL midrst_edge10_wait: SCLK edge 10 not seen"); end
      repeat (30) step();
      tests_run++; if (sclk !== 1'b0) begin tests_failed++; $display("FAIL midrst_pre_sclk: got %b expected 0", sclk); end
      #3 rst = 1'b1;
      #1;
      tests_run++; if (cs_n !== 1'b1) begin tests_failed++; $display("FAIL midrst_cs_n: got %b expected 1", cs_n); end
      tests_run++; if (sclk !== 1'b1) begin tests_failed++; $display("FAIL midrst_sclk: got %b expected 1", sclk); end
      tests_run++; if (voltage !== 12'h000) begin tests_failed++; $display("FAIL midrst_voltage: got %h expected 000", voltage); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      n = sv_count;
      repeat (3) step();
      rst = 1'b0; r1 = cyc;
      tests_run++; if (sv_count !== n) begin tests_failed++; $display("FAIL midrst_no_sv: got %0d pulses expected 0", sv_count - n); end
      pb = phase_bad;
      wait_sv(n, ok);
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL midrst_timeout: no frame after release"); end
      tests_run++; if (cs_fall_cyc !== r1 + 1) begin tests_failed++; $display("FAIL midrst_restart: cs_n fell at %0d expected %0d", cs_fall_cyc, r1 + 1); end
      tests_run++; if (voltage !== 12'h321) begin tests_failed++; $display("FAIL midrst_voltage_after: got %h expected 321", voltage); end
      tests_run++; if (phase_bad !== pb) begin tests_failed++; $display("FAIL midrst_phases: %0d bad phases expected 0", phase_bad - pb); end
      tests_run++; if (frame_rises !== 16) begin tests_failed++; $display("FAIL midrst_rises: got %0d expected 16", frame_rises); end
   endtask

   task automatic test_overrun();
      adc_word2 = 12'h9C4; en2 = 1'b1;
      step();
      rst2 = 1'b0; q = cyc;
      while (cyc < q + 900) step();
      tests_run++; if (voltage2 !== 12'h9C4) begin tests_failed++; $display("FAIL ovr_voltage1: got %h expected 9c4", voltage2); end
      tests_run++; if (sv2_count !== 1) begin tests_failed++; $display("FAIL ovr_sv1: got %0d expected 1", sv2_count); end
      tests_run++; if (cs2_fall_cyc !== q + 1) begin tests_failed++; $display("FAIL ovr_start1: got %0d expected %0d", cs2_fall_cyc, q + 1); end
      adc_word2 = 12'h2B7;
      while (cyc < q + 1900) step();
      tests_run++; if (voltage2 !== 12'h2B7) begin tests_failed++; $display("FAIL ovr_voltage2: got %h expected 2b7", voltage2); end
      tests_run++; if (sv2_count !== 2) begin tests_failed++; $display("FAIL ovr_sv2: got %0d expected 2", sv2_count); end
      tests_run++; if (sv2_cyc - sv2_prev_cyc !== 1000) begin tests_failed++; $display("FAIL ovr_interval: got %0d expected 1000", sv2_cyc - sv2_prev_cyc); end
      tests_run++; if (cs2_falls !== 2 || cs2_fall_cyc !== q + 1001) begin tests_failed++; $display("FAIL ovr_start2: %0d starts, last at %0d, expected 2 at %0d", cs2_falls, cs2_fall_cyc, q + 1001); end
      tests_run++; if (ov2_count !== 2) begin tests_failed++; $display("FAIL ovr_count: got %0d expected 2", ov2_count); end
      tests_run++; if (ov2_cyc !== q + 1501) begin tests_failed++; $display("FAIL ovr_timing: got %0d expected %0d", ov2_cyc, q + 1501); end
      tests_run++; if (ov2_long !== 0) begin tests_failed++; $display("FAIL ovr_width: %0d extra high cycles expected 0", ov2_long); end
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_frame();
      test_data_extremes();
      test_enable_gating();
      test_reset_mid_frame();
      test_overrun();
      tests_run++; if (ov_count !== 0) begin tests_failed++; $display("FAIL final_overrun: got %0d pulses expected 0", ov_count); end
      tests_run++; if (sv_long !== 0) begin tests_failed++; $display("FAIL final_sv_width: %0d extra high cycles expected 0", sv_long); end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
